sram_axi_bridge_mp: RTL
=======================

# sram_axi_bridge_mp

Parametrised multi-port bridge from SRAM-like request/response ports to a single AXI3 master, sitting between the pipelined CPU core and the SoC AXI crossbar in `mycpu_top`. It generalises the fixed instruction/data bridge to NRD read ports with per-port outstanding tracking and ID-routed responses, round-robin AR arbitration, and one write port. It adds an optional read-after-write address hazard check.

## Interface
- NRD, 2, number of read ports, 1..16; port i issues arid = i.
- MAX_OUT, 4, max outstanding reads per port, 1..15.
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- rd_req  in  NRD  per-port read request.
- rd_size  in  2*NRD  per-port size: 0 byte, 1 half, 2 word.
- rd_addr  in  32*NRD  per-port byte address.
- rd_addr_ok  out  NRD  request accepted (one-cycle pulse).
- rd_data  out  32  shared read data (= rdata).
- rd_data_ok  out  NRD  data valid for port rid.
- wr_req, wr_size[1:0], wr_addr[31:0], wr_data[31:0]  in  write request.
- wr_addr_ok  out  1  write accepted; wr_data_ok  out  1  write response.
- AXI3 master: arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0], arvalid out, arready in; rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid in, rready out; aw* mirroring ar*, awvalid out, awready in; wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid out, wready in; bid[3:0], bresp[1:0], bvalid in, bready out.

## Operation
- Constants: arlen/awlen 0, arburst/awburst 2'b01, lock/cache/prot 0, wlast 1, awid = wid = 0, arsize/awsize = {1'b0,size}.
- Read port eligible: rd_req & (outstanding[i] < MAX_OUT) & not hazard-blocked.
- AR slot: one register. Accepts when empty or arvalid&arready this cycle. Grant: round-robin among eligible ports starting at pointer; pointer moves to grantee+1 mod NRD. Grantee gets rd_addr_ok; slot loads addr/size/id.
- outstanding[i]: +1 on rd_addr_ok[i], −1 on rd_data_ok[i], unchanged if both; width clog2(MAX_OUT+1).
- rready = 1 constantly. rd_data_ok[i] = rvalid & (rid == i); rid ≥ NRD is consumed and discarded.
- Write FSM: IDLE → (wr_req: wr_addr_ok=1, latch addr/data/size) SEND → when AW and W both handshaken (independently, may differ in cycle) RESP → bvalid handshake: wr_data_ok=1 → IDLE.
- wstrb from size/addr[1:0]: byte 4'b0001<<a, half a[1]?4'b1100:4'b0011, word 4'b1111. wdata passed unmodified (core replicates lanes).
- awvalid/wvalid high in SEND until their own handshake; bready high only in RESP.

## Timing
- Reset: arvalid, awvalid, wvalid, bready, rd_addr_ok, wr_addr_ok, wr_data_ok 0; rready 1; counters 0; pointer 0; FSM IDLE.
- rd_addr_ok and wr_addr_ok combinational, same cycle as request; arvalid/awvalid/wvalid rise the next cycle.
- Min read latency: request cycle N, arvalid N+1; rd_data_ok combinational with rvalid.
- Back-to-back AR: new grant in the cycle arready completes the previous one; no bubble.
- Port at MAX_OUT: no rd_addr_ok until a data_ok frees a slot (a slot freed in cycle N may be granted in N+1).
- Write throughput: one write in flight; wr_addr_ok only in IDLE.
- Reset mid-transaction drops all state; no AXI completion is awaited.

## Configuration
- SRAM_AXI_RAW_CHECK_EN defined: a read is hazard-blocked while its addr[31:2] equals the latched write address and FSM ≠ IDLE, or equals wr_addr in a cycle wr_addr_ok is asserted (write ordered first). Released the cycle after wr_data_ok.
- Undefined: no comparison; reads and writes fully independent.

## Test plan
- Single read port 0, addr 0x1FC0_0000 size 2: arid 0, arsize 2, arlen 0; rvalid rid 0 rdata 0xDEADBEEF → rd_data_ok[0]=1, rd_data 0xDEADBEEF.
- NRD=2 both requesting every cycle, arready=1: grants alternate 0,1,0,1; each rd_addr_ok pulses every other cycle.
- MAX_OUT=4, port 1 requests 6 times, no rvalid: exactly 4 rd_addr_ok; fifth granted the cycle after first rid=1 response.
- Byte write addr 0x...03 data 0x11223344: wstrb 4'b1000; AW accepted cycle 2, W cycle 4 → bready rises after W; bvalid → wr_data_ok one pulse.
- With SRAM_AXI_RAW_CHECK_EN: write 0x100 then read 0x102 next cycle → no rd_addr_ok until cycle after wr_data_ok; without macro → read granted immediately.
- Assert resetn=0 with arvalid pending: all outputs reach reset values asynchronously; counters 0.

Source files
------------

// File: rtl/sram_axi_bridge_mp.sv
// Multi-port SRAM-like to AXI3 bridge: NRD round-robin read ports sharing one AR slot, one write port.
// Optional read-after-write hazard blocking is compiled in with `define SRAM_AXI_RAW_CHECK_EN.
module sram_axi_bridge_mp #(
    parameter int NRD     = 2,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NRD-1:0]    rd_req,
    input  logic [2*NRD-1:0]  rd_size,
    input  logic [32*NRD-1:0] rd_addr,
    output logic [NRD-1:0]    rd_addr_ok,
    output logic [31:0]       rd_data,
    output logic [NRD-1:0]    rd_data_ok,
    input  logic              wr_req,
    input  logic [1:0]        wr_size,
    input  logic [31:0]       wr_addr,
    input  logic [31:0]       wr_data,
    output logic              wr_addr_ok,
    output logic              wr_data_ok,
    output logic [3:0]        arid,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);
    localparam int PW = (NRD > 1) ? $clog2(NRD) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;
    wstate_t w_state_reg, w_state_next;

    logic [PW-1:0]  rr_ptr_reg;
    logic           ar_valid_reg;
    logic [31:0]    ar_addr_reg;
    logic [1:0]     ar_size_reg;
    logic [3:0]     ar_id_reg;
    logic [NRD-1:0] eligible, hazard, grant;
    logic           found;
    logic [PW-1:0]  grant_idx;
    logic           slot_free;
    logic           aw_done_reg, w_done_reg;
    logic [31:0]    wa_reg, wd_reg;
    logic [1:0]     ws_reg;
    logic           unused_inputs;

    assign unused_inputs = ^{rresp, rlast, bid, bresp};

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [CW-1:0] outst_reg;

            assign rd_data_ok[gi] = rvalid && (rid == 4'(gi));
            assign eligible[gi]   = rd_req[gi] && (outst_reg < CW'(MAX_OUT)) && !hazard[gi];
`ifdef SRAM_AXI_RAW_CHECK_EN
            // A write accepted this cycle is ordered ahead of a same-cycle read to its word.
            assign hazard[gi] = ((w_state_reg != W_IDLE) && (rd_addr[32*gi+2 +: 30] == wa_reg[31:2]))
                             || (wr_addr_ok && (rd_addr[32*gi+2 +: 30] == wr_addr[31:2]));
`else
            assign hazard[gi] = 1'b0;
`endif
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    outst_reg <= '0;
                else if (rd_addr_ok[gi] && !rd_data_ok[gi])
                    outst_reg <= outst_reg + 1'b1;
                else if (!rd_addr_ok[gi] && rd_data_ok[gi])
                    outst_reg <= outst_reg - 1'b1;
            end
        end
    endgenerate

    // The slot can take a new request in the same cycle its current one handshakes.
    assign slot_free = !ar_valid_reg || arready;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!found && eligible[(int'(rr_ptr_reg) + k) % NRD]) begin
                found     = 1'b1;
                grant_idx = PW'((int'(rr_ptr_reg) + k) % NRD);
            end
        end
        if (found && slot_free && resetn)
            grant[grant_idx] = 1'b1;
    end

    assign rd_addr_ok = grant;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rr_ptr_reg <= '0;
        else if (|grant)
            rr_ptr_reg <= (int'(grant_idx) == NRD - 1) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_valid_reg <= 1'b0;
            ar_addr_reg  <= '0;
            ar_size_reg  <= '0;
            ar_id_reg    <= '0;
        end else if (|grant) begin
            ar_valid_reg <= 1'b1;
            ar_addr_reg  <= rd_addr[32*int'(grant_idx) +: 32];
            ar_size_reg  <= rd_size[2*int'(grant_idx) +: 2];
            ar_id_reg    <= 4'(grant_idx);
        end else if (arready) begin
            ar_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            w_state_reg <= W_IDLE;
        else
            w_state_reg <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (wr_req) w_state_next = W_SEND;
            W_SEND:  if ((aw_done_reg || awready) && (w_done_reg || wready)) w_state_next = W_RESP;
            W_RESP:  if (bvalid) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        wr_addr_ok = resetn && (w_state_reg == W_IDLE) && wr_req;
        awvalid    = (w_state_reg == W_SEND) && !aw_done_reg;
        wvalid     = (w_state_reg == W_SEND) && !w_done_reg;
        bready     = (w_state_reg == W_RESP);
        wr_data_ok = (w_state_reg == W_RESP) && bvalid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            wa_reg      <= '0;
            wd_reg      <= '0;
            ws_reg      <= '0;
        end else if (wr_addr_ok) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            wa_reg      <= wr_addr;
            wd_reg      <= wr_data;
            ws_reg      <= wr_size;
        end else begin
            if (awvalid && awready) aw_done_reg <= 1'b1;
            if (wvalid && wready)   w_done_reg  <= 1'b1;
        end
    end

    always_comb begin
        case (ws_reg)
            2'd0:    wstrb = 4'b0001 << wa_reg[1:0];
            2'd1:    wstrb = wa_reg[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign arvalid = ar_valid_reg;
    assign araddr  = ar_addr_reg;
    assign arsize  = {1'b0, ar_size_reg};
    assign arid    = ar_id_reg;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign rready  = 1'b1;
    assign rd_data = rdata;
    assign awid    = 4'd0;
    assign awaddr  = wa_reg;
    assign awsize  = {1'b0, ws_reg};
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = 4'd0;
    assign wdata   = wd_reg;
    assign wlast   = 1'b1;
endmodule
